// File: rtl/timer_pkg.sv
// Shared types and TMxCNT_H field positions for the timer scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (no handshakes).
package timer_pkg;

  typedef enum logic [1:0] {
    PS_1    = 2'd0,
    PS_64   = 2'd1,
    PS_256  = 2'd2,
    PS_1024 = 2'd3
  } prescale_e;

  localparam int TM_START_BIT   = 7;
  localparam int TM_IRQ_BIT     = 6;
  localparam int TM_CASCADE_BIT = 2;
  localparam int PC_W           = 10;

  // Low-k-bit mask of the prescale counter: a tick is due when all masked bits are 1.
  function automatic logic [PC_W-1:0] prescale_mask(input prescale_e sel);
    case (sel)
      PS_1:    prescale_mask = 10'h000;
      PS_64:   prescale_mask = 10'h03f;
      PS_256:  prescale_mask = 10'h0ff;
      default: prescale_mask = 10'h3ff;
    endcase
  endfunction

endpackage

// File: rtl/timer_chan_sched.sv
// One timer channel: start-edge detect, prescaler, cascade tick, load and IRQ strobes.
// Latency: 1 cycle from start rise to load, from ovf to irq, from cascade_in to tick_en.
// Backpressure: none; strobes are fire-and-forget single-cycle pulses.
module timer_chan_sched
  import timer_pkg::*;
(
  input  logic       clock_16,
  input  logic       reset_n,
  input  logic [1:0] sel,
  input  logic       cascade_bit,
  input  logic       irq_en,
  input  logic       start,
  input  logic       cascade_allowed,
  input  logic       cascade_in,
  input  logic       ovf,
  output logic       load,
  output logic       tick_en,
  output logic       irq,
  output logic       running
);

  logic            start_q;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] mask;
  logic            rise;
  logic            active;
  logic            casc_mode;

  // rise: first cycle start is seen high; active: start held, i.e. load cycle and beyond.
  assign rise      = start & ~start_q;
  assign active    = start & start_q;
  assign casc_mode = cascade_allowed & cascade_bit;
  assign mask      = prescale_mask(prescale_e'(sel));

  // Per-channel sequencing; every output is a flop so nothing is combinational from inputs.
  always_ff @(posedge clock_16 or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= 1'b0;
      pc      <= '0;
      load    <= 1'b0;
      tick_en <= 1'b0;
      irq     <= 1'b0;
      running <= 1'b0;
    end else begin
      start_q <= start;
      load    <= rise;
      running <= active;
      // A same-cycle start rise still reports the overflow of the old count.
      irq     <= ovf & irq_en & (running | rise);
      if (rise) begin
        pc <= '0;
      end else if (active && !casc_mode) begin
        pc <= pc + 10'd1;
      end
      if (casc_mode) begin
        // Upstream overflows during the load cycle or while stopped are dropped.
        tick_en <= cascade_in & running & start;
      end else begin
        tick_en <= active & ((pc & mask) == mask);
      end
    end
  end

endmodule

// File: rtl/timer_sched.sv
// Scheduler for the four timer datapaths: decodes TMxCNT_H and chains overflows ch(x-1)->ch(x).
// Latency: 1 cycle per stage (start->load, ovf->irq, ovf[x-1]->tick_en[x]).
// Backpressure: none; datapaths and the interrupt controller must take every strobe.
module timer_sched
  import timer_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic                    clock_16,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0][15:0] tmcnt_h,
  input  logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH-1:0]       load,
  output logic [NUM_CH-1:0]       tick_en,
  output logic [NUM_CH-1:0]       irq,
  output logic [NUM_CH-1:0]       running
);

  logic [NUM_CH-1:0] casc_in;
  logic [NUM_CH-1:0] casc_ok;

  // Channel 0 has no upstream, so its count-up bit is ignored.
  assign casc_in = {ovf[NUM_CH-2:0], 1'b0};
  assign casc_ok = {{(NUM_CH-1){1'b1}}, 1'b0};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [10:0] ctl_unused;
    assign ctl_unused = {tmcnt_h[i][15:8], tmcnt_h[i][5:3]};

    timer_chan_sched u_chan (
      .clock_16        (clock_16),
      .reset_n         (reset_n),
      .sel             (tmcnt_h[i][1:0]),
      .cascade_bit     (tmcnt_h[i][TM_CASCADE_BIT]),
      .irq_en          (tmcnt_h[i][TM_IRQ_BIT]),
      .start           (tmcnt_h[i][TM_START_BIT]),
      .cascade_allowed (casc_ok[i]),
      .cascade_in      (casc_in[i]),
      .ovf             (ovf[i]),
      .load            (load[i]),
      .tick_en         (tick_en[i]),
      .irq             (irq[i]),
      .running         (running[i])
    );
  end

endmodule

// File: tb/tb_timer_sched.sv
// Self-checking bench for timer_sched: directed scenarios with literal expectations plus
// a long randomized run, all outputs compared every cycle against a behavioural model.
module tb_timer_sched;
  localparam int NUM_CH = 4;

  logic                    clock_16 = 1'b0;
  logic                    reset_n;
  logic [NUM_CH-1:0][15:0] tmcnt_h;
  logic [NUM_CH-1:0]       ovf;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH-1:0]       tick_en;
  logic [NUM_CH-1:0]       irq;
  logic [NUM_CH-1:0]       running;

  timer_sched #(.NUM_CH(NUM_CH)) dut (
    .clock_16 (clock_16),
    .reset_n  (reset_n),
    .tmcnt_h  (tmcnt_h),
    .ovf      (ovf),
    .load     (load),
    .tick_en  (tick_en),
    .irq      (irq),
    .running  (running)
  );

  always #5 clock_16 = ~clock_16;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Each channel is described by: was start seen last cycle, whether it is running,
  // and how many prescale cycles have elapsed since its load (mod 1024).
  bit [NUM_CH-1:0] m_start_seen;
  bit [NUM_CH-1:0] m_load, m_tick, m_irq, m_run;
  int              m_elapsed [NUM_CH];

  function automatic int period_of(input logic [1:0] sel);
    case (sel)
      2'd0:    return 1;
      2'd1:    return 64;
      2'd2:    return 256;
      default: return 1024;
    endcase
  endfunction

  // Single compare process: outputs are checked mid-cycle, then the model advances.
  always @(negedge clock_16) begin
    bit [NUM_CH-1:0] n_load, n_tick, n_irq, n_run;
    if (!reset_n) begin
      m_start_seen = '0;
      m_load = '0; m_tick = '0; m_irq = '0; m_run = '0;
      for (int c = 0; c < NUM_CH; c++) m_elapsed[c] = 0;
    end
    chk("load", load, m_load);
    chk("tick_en", tick_en, m_tick);
    chk("irq", irq, m_irq);
    chk("running", running, m_run);
    chk("load_tick_excl", load & tick_en, 0);
    if (reset_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        bit s, first, held, chained;
        s       = tmcnt_h[c][7];
        first   = s && !m_start_seen[c];
        held    = s && m_start_seen[c];
        chained = (c != 0) && tmcnt_h[c][2];
        n_load[c] = first;
        n_run[c]  = held;
        n_irq[c]  = ovf[c] && tmcnt_h[c][6] && (m_run[c] || first);
        n_tick[c] = 1'b0;
        if (chained) begin
          if (m_run[c] && s && ovf[c-1]) n_tick[c] = 1'b1;
        end else if (held && ((m_elapsed[c] + 1) % period_of(tmcnt_h[c][1:0]) == 0)) begin
          n_tick[c] = 1'b1;
        end
        if (first) m_elapsed[c] = 0;
        else if (held && !chained) m_elapsed[c] = (m_elapsed[c] + 1) % 1024;
        m_start_seen[c] = s;
      end
      m_load = n_load; m_tick = n_tick; m_irq = n_irq; m_run = n_run;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cyc();
    @(posedge clock_16);
    #1;
  endtask

  initial begin
    int load_at, nload, first_tick, last_tick, ntick, npulse;
    reset_n = 1'b0;
    tmcnt_h = '0;
    ovf     = '0;
    tmcnt_h[0] = 16'h0080;

    // Reset state, then release with ch0 start already set.
    next_cyc(); next_cyc();
    @(negedge clock_16);
    chk("rst_load", load, 0);
    chk("rst_tick", tick_en, 0);
    chk("rst_irq", irq, 0);
    chk("rst_running", running, 0);
    next_cyc(); reset_n = 1'b1;
    next_cyc(); @(negedge clock_16);
    chk("t1_load0", load[0], 1);
    chk("t1_tick0_in_load", tick_en[0], 0);
    chk("t1_running0_in_load", running[0], 0);
    next_cyc(); @(negedge clock_16);
    chk("t1_tick0", tick_en[0], 1);
    chk("t1_running0", running[0], 1);
    chk("t1_load0_once", load[0], 0);

    // ch1 F/64: load at +1, ticks at +65, +129, +193.
    next_cyc(); tmcnt_h[1] = 16'h0081;
    load_at = -1; nload = 0; first_tick = -1; last_tick = -1; ntick = 0;
    for (int i = 1; i <= 200; i++) begin
      next_cyc(); @(negedge clock_16);
      if (load[1]) begin nload++; load_at = i; end
      if (tick_en[1]) begin ntick++; if (first_tick < 0) first_tick = i; last_tick = i; end
    end
    chk("t2_load_at", load_at, 1);
    chk("t2_nload", nload, 1);
    chk("t2_first_tick", first_tick, 65);
    chk("t2_last_tick", last_tick, 193);
    chk("t2_ntick", ntick, 3);

    // ch1 count-up: running passes one tick, stopped drops it.
    next_cyc(); tmcnt_h[1] = 16'h0084;
    next_cyc(); next_cyc(); next_cyc();
    ovf[0] = 1'b1;
    next_cyc(); ovf[0] = 1'b0; @(negedge clock_16);
    chk("t3_casc_tick", tick_en[1], 1);
    next_cyc(); @(negedge clock_16);
    chk("t3_casc_once", tick_en[1], 0);
    next_cyc(); tmcnt_h[1] = 16'h0004;
    next_cyc(); next_cyc();
    ovf[0] = 1'b1;
    next_cyc(); ovf[0] = 1'b0; @(negedge clock_16);
    chk("t3_stopped_tick", tick_en[1], 0);
    chk("t3_stopped_running", running[1], 0);

    // ch2 IRQ enable on, then off.
    next_cyc(); tmcnt_h[2] = 16'h00c0;
    next_cyc(); next_cyc(); next_cyc();
    ovf[2] = 1'b1;
    next_cyc(); ovf[2] = 1'b0; @(negedge clock_16);
    chk("t4_irq", irq[2], 1);
    next_cyc(); @(negedge clock_16);
    chk("t4_irq_once", irq[2], 0);
    next_cyc(); tmcnt_h[2] = 16'h0080; ovf[2] = 1'b1;
    next_cyc(); ovf[2] = 1'b0; @(negedge clock_16);
    chk("t4_irq_disabled", irq[2], 0);

    // ch0 F/1024: run ~500 cycles, stop 20, restart; first tick 1024 after new load.
    next_cyc(); tmcnt_h[0] = 16'h0000;
    next_cyc(); tmcnt_h[0] = 16'h0083;
    repeat (501) next_cyc();
    tmcnt_h[0] = 16'h0003;
    repeat (20) next_cyc();
    @(negedge clock_16);
    chk("t5_stopped_running", running[0], 0);
    next_cyc(); tmcnt_h[0] = 16'h0083;
    load_at = -1; nload = 0; first_tick = -1; ntick = 0;
    for (int i = 1; i <= 1030; i++) begin
      next_cyc(); @(negedge clock_16);
      if (load[0]) begin nload++; load_at = i; end
      if (tick_en[0]) begin ntick++; if (first_tick < 0) first_tick = i; end
    end
    chk("t5_load_at", load_at, 1);
    chk("t5_nload", nload, 1);
    chk("t5_first_tick", first_tick, 1025);
    chk("t5_ntick", ntick, 1);
    next_cyc(); tmcnt_h[0] = 16'h00c3;
    nload = 0;
    for (int i = 0; i < 5; i++) begin
      next_cyc(); tmcnt_h[0] = 16'h00c3; @(negedge clock_16);
      if (load[0]) nload++;
    end
    chk("t5_rewrite_no_load", nload, 0);

    // Asynchronous reset with irq/tick pending.
    next_cyc(); tmcnt_h[0] = 16'h0080; tmcnt_h[2] = 16'h00c0;
    next_cyc(); next_cyc();
    ovf[2] = 1'b1;
    next_cyc(); ovf[2] = 1'b0;
    chk("t6_pre_irq", irq[2], 1);
    chk("t6_pre_tick", tick_en[0], 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_load", load, 0);
    chk("t6_async_tick", tick_en, 0);
    chk("t6_async_irq", irq, 0);
    chk("t6_async_running", running, 0);
    tmcnt_h = '0;
    next_cyc(); next_cyc(); reset_n = 1'b1;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      next_cyc(); @(negedge clock_16);
      if (|{load, tick_en, irq, running}) npulse++;
    end
    chk("t6_no_pulse_after", npulse, 0);

    // Randomized run, checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      next_cyc();
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 39) == 0) tmcnt_h[c][7] = ~tmcnt_h[c][7];
        if ($urandom_range(0, 59) == 0) begin
          tmcnt_h[c][1:0] = 2'($urandom_range(0, 3));
          tmcnt_h[c][2]   = 1'($urandom_range(0, 1));
          tmcnt_h[c][6]   = 1'($urandom_range(0, 1));
          tmcnt_h[c][15:8] = 8'($urandom_range(0, 255));
        end
        ovf[c] = ($urandom_range(0, 3) == 0);
      end
    end
    ovf = '0;
    next_cyc();
    @(negedge clock_16);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
